// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers for the EX stage.
// Build option: define MDU_MADD_EN to enable MADD/MADDU (ops 6/7) accumulate into {hi,lo}.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MADDU = 3'd7
  } op_e;

  typedef enum logic { IDLE, RUN } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  op_e               op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d;

  logic [2*WIDTH-1:0] prod_s, prod_u, res;
  logic               res_wr;

  // Full-width products from sign/zero-extended latched operands.
  assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // One unsigned divider shared by DIV/DIVU; signed ops go through magnitudes,
  // which also yields most-negative/-1 -> quotient most-negative, remainder 0.
  logic             div_sgn;
  logic [WIDTH-1:0] a_mag, b_mag, b_div, quo_mag, rem_mag, quo, rem;

  assign div_sgn = (op_q == OP_DIV);
  assign a_mag   = (div_sgn && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag   = (div_sgn && b_q[WIDTH-1]) ? -b_q : b_q;
  assign b_div   = (b_q == '0) ? WIDTH'(1) : b_mag;
  assign quo_mag = a_mag / b_div;
  assign rem_mag = a_mag % b_div;
  assign quo     = (div_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_mag : quo_mag;
  assign rem     = (div_sgn && a_q[WIDTH-1]) ? -rem_mag : rem_mag;

  always_comb begin
    res_wr = 1'b1;
    res    = {hi_q, lo_q};
    case (op_q)
      OP_MULT:          res = prod_s;
      OP_MULTU:         res = prod_u;
      OP_DIV, OP_DIVU: begin
        if (b_q == '0) res_wr = 1'b0;
        else           res    = {rem, quo};
      end
`ifdef MDU_MADD_EN
      // hi/lo cannot change while busy, so the current value is the start-edge value.
      OP_MADD:          res = {hi_q, lo_q} + prod_s;
      OP_MADDU:         res = {hi_q, lo_q} + prod_u;
`endif
      default:          res_wr = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_e'(op))
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_DIV, OP_DIVU: begin
              op_d    = op_e'(op);
              a_d     = a;
              b_d     = b;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
`ifdef MDU_MADD_EN
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU: begin
`else
            OP_MULT, OP_MULTU: begin
`endif
              op_d    = op_e'(op);
              a_d     = a;
              b_d     = b;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (res_wr) {hi_d, lo_d} = res;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected {hi,lo} and busy length queued at issue,
// compared when busy drops.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_hi = '0, m_lo = '0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op, optionally poke a second start while busy, then pop and compare.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                       input int cyc, input bit intrude);
    exp_t e;
    int   n;
    sb.push_back('{tag, eh, el, cyc});
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    n = 0;
    while (busy && n < 100) begin
      if (intrude && n == 1) begin
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_busy_cycles"}, 64'(n), 64'(e.cyc));
      chk({e.tag, "_hi"}, 64'(hi), 64'(e.hi));
      chk({e.tag, "_lo"}, 64'(lo), 64'(e.lo));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    do_op("mult_neg1x2",  3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 1'b0);
    do_op("multu_maxx2",  3'd1, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 1'b0);
    do_op("div_m7_2",     3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
    do_op("divu_7_2",     3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0);
    do_op("div_7_m2",     3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10, 1'b0);
    do_op("div_ovf",      3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 1'b0);
    do_op("divu_big",     3'd3, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 10, 1'b0);

    do_op("mthi", 3'd4, 32'h12345678, 32'd0, 32'h12345678, m_lo, 0, 1'b0);
    do_op("mtlo", 3'd5, 32'h9ABCDEF0, 32'd0, 32'h12345678, 32'h9ABCDEF0, 0, 1'b0);
    do_op("divu_by0", 3'd3, 32'd55, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10, 1'b0);
    do_op("div_by0",  3'd2, 32'hFFFFFF00, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10, 1'b0);

    do_op("mult_3x4_intr", 3'd0, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b1);

    // Asynchronous reset in the third busy cycle of a second MULT.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_pre_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_post_busy", 64'(busy), 64'd0);
    chk("rst_post_hi", 64'(hi), 64'd0);
    chk("rst_post_lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0;

    do_op("madd_mtlo", 3'd5, 32'd10, 32'd0, 32'd0, 32'd10, 0, 1'b0);
`ifdef MDU_MADD_EN
    do_op("madd_3x4", 3'd6, 32'd3, 32'd4, 32'd0, 32'd22, 5, 1'b0);
    do_op("maddu_acc", 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd23, 5, 1'b0);
`else
    do_op("madd_off", 3'd6, 32'd3, 32'd4, 32'd0, 32'd10, 0, 1'b0);
    do_op("maddu_off", 3'd7, 32'd3, 32'd4, 32'd0, 32'd10, 0, 1'b0);
`endif

    // Randomised arithmetic against the bench's own integer model.
    for (int i = 0; i < 12; i++) begin
      logic [31:0]     av, bv;
      int              ia, ib, q, r;
      longint          ps;
      longint unsigned pu;
      av = $urandom; bv = $urandom;
      if (i % 4 == 3) bv = bv >> (i + 8);
      if (bv == 0) bv = 32'd3;
      ia = av; ib = bv;
      case (i % 4)
        0: begin
          ps = longint'(ia) * longint'(ib);
          do_op("rnd_mult", 3'd0, av, bv, ps[63:32], ps[31:0], 5, 1'b0);
        end
        1: begin
          pu = {32'd0, av} * {32'd0, bv};
          do_op("rnd_multu", 3'd1, av, bv, pu[63:32], pu[31:0], 5, 1'b0);
        end
        2: begin
          if (ia == 32'sh80000000 && ib == -1) ib = 5;
          bv = ib;
          q = ia / ib; r = ia % ib;
          do_op("rnd_div", 3'd2, av, bv, r, q, 10, 1'b0);
        end
        default: begin
          do_op("rnd_divu", 3'd3, av, bv, av % bv, av / bv, 10, 1'b0);
        end
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with its own HI/LO registers for the next-generation pipelined MIPS core. Sits in the EX stage beside the ALU.
- Accepts one operation per start pulse and holds busy for a parametrised latency. The hazard logic stalls mfhi/mflo and new MDU instructions while busy or start is high.
- Adds multi-cycle arithmetic and architectural HI/LO state, which the single-cycle core lacks.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy duration for mult/multu/madd/maddu; must be >= 1.
- DIV_CYCLES, 10, busy duration for div/divu; must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; op, a and b are sampled on the same edge
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
- a  input  WIDTH  rs operand
- b  input  WIDTH  rt operand
- busy  output  1  computation in flight
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: asynchronous; busy=0, hi=0, lo=0, internal counter=0, latched operands cleared.
  - Reset mid-operation aborts the operation and discards the pending result.
- States: IDLE (counter==0) and RUN (counter>0).
- IDLE, start=1, arithmetic op (0-3, 6-7) on edge E:
  - Latch op, a and b.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from E onward.
- RUN: counter decrements every edge. On the edge where counter goes 1->0:
  - hi and lo are written with the result.
  - busy falls on that same edge.
  - So busy is high for exactly N cycles, and the result is visible in the first cycle busy is low.
- MTHI/MTLO while in IDLE with start=1: single-edge write of a into hi or lo; busy stays 0.
- start while busy is ignored; op, a and b are not latched and in-flight state is unchanged. Upstream must not issue it.
- start with op 6/7 when MDU_MADD_EN is undefined: no-op; no busy, hi/lo unchanged.
- Arithmetic rules (operands taken from the latched copies):
  - MULT: {hi,lo} = signed a * signed b, full 2*WIDTH product.
  - MULTU: unsigned full product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Divide by zero: the operation still takes DIV_CYCLES and busy behaves normally; hi and lo are left unchanged at completion.
- Signed overflow, most-negative / -1: lo = most-negative, hi = 0, no trap.
- Latched operands isolate the result from changes on a/b after the start edge.
- The result may be computed combinationally from the latched operands. Only the commit time is architectural.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op 6 MADD computes {hi,lo} += signed a*b; op 7 MADDU computes {hi,lo} += unsigned a*b.
  - Accumulation is mod 2^(2*WIDTH).
  - The {hi,lo} value used is the one present at the start edge.
  - Latency is MULT_CYCLES.
- Undefined: ops 6/7 are no-ops, as above. Accumulate logic is not synthesised.

Test Plan:
- Reset, then MULT a=0xFFFFFFFF b=2 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU a=0xFFFFFFFF b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also DIVU 7/2 -> lo=3, hi=1.
- MTHI a=0x12345678, next cycle MTLO a=0x9ABCDEF0 -> busy never rises; hi and lo take those values on the respective edges. Then DIVU with b=0 -> busy 10 cycles; hi/lo remain 0x12345678/0x9ABCDEF0.
- MULT 3*4 started; change a/b and pulse start with DIV during busy; assert reset asynchronously at cycle 3 of a second MULT -> first result is hi=0, lo=12 with the DIV ignored; after reset, busy=0 immediately and hi=lo=0.
- With MDU_MADD_EN: MTLO 10, then MADD a=3 b=4 -> lo=22, hi=0 after 5 cycles. Without MDU_MADD_EN, the same sequence leaves lo=10 and busy stays 0.
